// File: rtl/mac_accumulator_if.sv
// Valid/ready bundle for mac_accumulator: activation/weight beats in, wide dot-product sums out.
interface mac_accumulator_if #(
  parameter int unsigned ACT_W     = 12,
  parameter int unsigned WT_W      = 12,
  parameter int unsigned MAX_TERMS = 16
);
  localparam int unsigned ACC_W = ACT_W + WT_W + $clog2(MAX_TERMS);

  logic             in_valid;
  logic             in_ready;
  logic [ACT_W-1:0] in_act;
  logic [WT_W-1:0]  in_wt;
  logic             in_first;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;

  modport master (
    output in_valid, in_act, in_wt, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_act, in_wt, in_first, in_last, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/mac_accumulator.sv
// Two-stage streaming multiply-accumulate: registered product, then burst accumulator with
// a held result register; full-precision sum with 2 sign bits for the downstream bit_scaler.
module mac_accumulator #(
  parameter int unsigned ACT_W     = 12,
  parameter int unsigned ACT_INT   = 3,
  parameter int unsigned WT_W      = 12,
  parameter int unsigned WT_INT    = 3,
  parameter int unsigned MAX_TERMS = 16
) (
  input  logic               clk,
  input  logic               reset,
  mac_accumulator_if.slave   bus,
  output logic               err_ovf
);
  localparam int unsigned GUARD  = $clog2(MAX_TERMS);
  localparam int unsigned PROD_W = ACT_W + WT_W;
  localparam int unsigned ACC_W  = PROD_W + GUARD;
  localparam int unsigned CNT_W  = GUARD + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TERMS);

  // Integer fields must leave room for the sign bit of each operand format.
  if (ACT_INT >= ACT_W || WT_INT >= WT_W) begin : g_bad_format
    $error("mac_accumulator: integer bits exceed operand width");
  end

  logic                     advance;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  p1;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  sum_q;
  logic                     v1;
  logic                     f1;
  logic                     l1;
  logic                     vld_q;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_next;
  logic                     cnt_ovf;

  // Stall only when a result is waiting and the consumer refuses it.
  always_comb begin
    advance  = !vld_q || bus.out_ready;
    prod     = PROD_W'($signed(bus.in_act)) * PROD_W'($signed(bus.in_wt));
    acc_next = (f1 ? '0 : acc) + p1;
    cnt_next = cnt;
    if (f1) begin
      cnt_next = CNT_W'(1);
    end else if (cnt <= CNT_MAX) begin
      cnt_next = cnt + CNT_W'(1);
    end
    cnt_ovf = (cnt_next > CNT_MAX);
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_q;
  assign bus.out_sum   = sum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      p1      <= '0;
      v1      <= 1'b0;
      f1      <= 1'b0;
      l1      <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      sum_q   <= '0;
      vld_q   <= 1'b0;
      err_ovf <= 1'b0;
    end else if (advance) begin
      p1 <= ACC_W'(prod);
      v1 <= bus.in_valid;
      f1 <= bus.in_first;
      l1 <= bus.in_last;

      // A completing burst refills the result register even while the old one is being taken.
      if (v1 && l1) begin
        vld_q <= 1'b1;
      end else if (bus.out_ready) begin
        vld_q <= 1'b0;
      end

      if (v1) begin
        if (cnt_ovf) begin
          err_ovf <= 1'b1;
        end
        if (l1) begin
          sum_q <= acc_next;
          acc   <= '0;
          cnt   <= '0;
        end else begin
          acc   <= acc_next;
          cnt   <= cnt_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed cases plus randomized bursts against a
// per-burst integer dot-product model with a queue of expected sums.
module tb_mac_accumulator;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_ovf;

  always #5 clk = ~clk;

  mac_accumulator_if bus ();

  mac_accumulator dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .err_ovf (err_ovf)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_deliv = 0;
  logic [27:0] exp_q[$];
  logic [27:0] last_sum = '0;
  longint      m_sum = 0;
  longint      m_p = 0;
  int          m_cnt = 0;
  logic        m_err = 1'b0;
  bit          rnd_rdy = 1'b0;
  bit          hold_prev = 1'b0;
  logic [27:0] held_sum = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, got, want, $time);
    end
  endtask

  // Reference: dot product of each first..last burst, computed with plain integers.
  always @(negedge clk) begin
    if (reset) begin
      m_sum = 0;
      m_cnt = 0;
      m_err = 1'b0;
      exp_q.delete();
    end else if (bus.in_valid && bus.in_ready) begin
      m_p   = longint'($signed(bus.in_act)) * longint'($signed(bus.in_wt));
      m_sum = bus.in_first ? m_p : m_sum + m_p;
      m_cnt = bus.in_first ? 1 : m_cnt + 1;
      if (m_cnt > 16) m_err = 1'b1;
      if (bus.in_last) begin
        exp_q.push_back(m_sum[27:0]);
        m_sum = 0;
        m_cnt = 0;
      end
    end
  end

  // Output checker: handshake rule, hold-while-stalled, and in-order results.
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready_rule", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
      if (hold_prev) begin
        chk("stall_hold_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_hold_sum", 64'(bus.out_sum), 64'(held_sum));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(bus.out_valid), 64'd0);
        end else begin
          chk("sum", 64'(bus.out_sum), 64'(exp_q.pop_front()));
          last_sum = bus.out_sum;
          n_deliv++;
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      held_sum  = bus.out_sum;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [11:0] a, input logic [11:0] w, input logic f, input logic l);
    logic rdy;
    int   t;
    bus.in_valid = 1'b1;
    bus.in_act   = a;
    bus.in_wt    = w;
    bus.in_first = f;
    bus.in_last  = l;
    t = 0;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      tick();
      t++;
    end while (!rdy && t < 300);
    if (!rdy) chk("send_timeout", 64'(rdy), 64'd1);
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 500) begin
      tick();
      t++;
    end
    if (t >= 500) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    int d0;
    int len;
    bit nofirst;
    bus.in_valid  = 1'b0;
    bus.in_act    = '0;
    bus.in_wt     = '0;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
    chk("rst_err_ovf", 64'(err_ovf), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // 4 x (1.0 * 1.0), latency and single-cycle valid pulse
    for (int i = 0; i < 4; i++) send(12'h100, 12'h100, 1'(i == 0), 1'(i == 3));
    chk("t1_not_yet", 64'(bus.out_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_sum", 64'(bus.out_sum), 64'h0040000);
    tick();
    chk("t1_pulse", 64'(bus.out_valid), 64'd0);

    // single-term burst, negative weight
    send(12'h2ff, 12'hf00, 1'b1, 1'b1);
    chk("t2_model", 64'(exp_q[0]), 64'hffd0100);
    tick();
    chk("t2_valid", 64'(bus.out_valid), 64'd1);
    chk("t2_sum", 64'(bus.out_sum), 64'hffd0100);
    drain();

    // back-to-back results under backpressure
    bus.out_ready = 1'b0;
    d0 = n_deliv;
    send(12'h010, 12'h020, 1'b1, 1'b1);
    send(12'h7ff, 12'h801, 1'b1, 1'b1);
    tick();
    tick();
    chk("t3_in_ready_low", 64'(bus.in_ready), 64'd0);
    chk("t3_held_sum", 64'(bus.out_sum), 64'h0000200);
    repeat (3) tick();
    chk("t3_still_held", 64'(bus.out_sum), 64'h0000200);
    bus.out_ready = 1'b1;
    drain();
    chk("t3_delivered", 64'(n_deliv - d0), 64'd2);
    chk("t3_second_sum", 64'(last_sum), 64'hfc00fff);

    // full-length burst, then an overlong one
    for (int i = 0; i < 16; i++) send(12'h800, 12'h800, 1'(i == 0), 1'(i == 15));
    drain();
    chk("t4_sum16", 64'(last_sum), 64'h4000000);
    chk("t4_no_err", 64'(err_ovf), 64'd0);
    for (int i = 0; i < 17; i++) send(12'h800, 12'h800, 1'(i == 0), 1'(i == 16));
    drain();
    chk("t4_sum17", 64'(last_sum), 64'h4400000);
    chk("t4_err", 64'(err_ovf), 64'd1);
    chk("t4_err_model", 64'(err_ovf), 64'(m_err));
    send(12'h100, 12'h100, 1'b1, 1'b0);
    send(12'h100, 12'h100, 1'b0, 1'b1);
    drain();
    chk("t4_err_sticky", 64'(err_ovf), 64'd1);

    // reset mid-burst discards the partial sum
    send(12'h300, 12'h300, 1'b1, 1'b0);
    send(12'h300, 12'h300, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("t5_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_rst_sum", 64'(bus.out_sum), 64'd0);
    chk("t5_rst_err", 64'(err_ovf), 64'd0);
    chk("t5_rst_ready", 64'(bus.in_ready), 64'd1);
    send(12'h100, 12'h100, 1'b1, 1'b0);
    send(12'h100, 12'h100, 1'b0, 1'b1);
    drain();
    chk("t5_sum", 64'(last_sum), 64'h0020000);

    // random bursts with random backpressure and gaps
    rnd_rdy = 1'b1;
    d0 = n_deliv;
    for (int b = 0; b < 60; b++) begin
      len     = int'($urandom_range(1, 16));
      nofirst = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < len; i++) begin
        send(12'($urandom), 12'($urandom), 1'(i == 0 && !nofirst), 1'(i == len - 1));
        if ($urandom_range(0, 3) == 0) tick();
      end
    end
    bus.out_ready = 1'b1;
    rnd_rdy = 1'b0;
    drain();
    chk("t6_delivered", 64'(n_deliv - d0), 64'd60);
    chk("t6_no_err", 64'(err_ovf), 64'd0);
    chk("t6_err_model", 64'(err_ovf), 64'(m_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
